obj_line_pingpong_buffer: RTL and testbench

//  Parametrised ping-pong OBJ line buffer between the sprite renderer and the compositor.
//  - The renderer fills the "render" bank for line N+1 while the compositor reads the "display" bank for line N.
//  - Adds over the previous buffer: OBJ-priority arbitration, semi-transparent and OBJ-window flags,

---
 rtl/obj_line_pingpong_buffer_pkg.sv | 19 +
 rtl/obj_line_pingpong_buffer_if.sv | 36 +++
 rtl/obj_line_pingpong_buffer_bank.sv | 69 ++++++
 rtl/obj_line_pingpong_buffer.sv | 120 ++++++++++++
 tb/tb_obj_line_pingpong_buffer.sv | 233 +++++++++++++++++++++++
 5 files changed

// File: rtl/obj_line_pingpong_buffer_pkg.sv
// Shared types and default sizes for the OBJ ping-pong line buffer.
package obj_line_pingpong_buffer_pkg;
  localparam int OBJ_COLS    = 240;
  localparam int OBJ_COLOR_W = 16;
  localparam int OBJ_PRIO_W  = 2;

  typedef struct packed {
    logic                   opaque;
    logic [OBJ_PRIO_W-1:0]  prio;
    logic                   semi;
    logic                   objwin;
    logic [OBJ_COLOR_W-1:0] color;
  } obj_entry_t;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SWEEP = 1'b1
  } obj_state_e;
endpackage

// File: rtl/obj_line_pingpong_buffer_if.sv
// Renderer/compositor side of the OBJ line buffer: write port, read port and bank control.
interface obj_line_pingpong_buffer_if #(
  parameter int COL_W   = 8,
  parameter int COLOR_W = 16,
  parameter int PRIO_W  = 2
);
  logic               swap;
  logic               flush;
  logic               busy;
  logic               bank;
  logic               we;
  logic [COL_W-1:0]   wcol;
  logic [COLOR_W-1:0] wcolor;
  logic [PRIO_W-1:0]  wprio;
  logic               wsemi;
  logic               wobjwin;
  logic               wtransparent;
  logic               re;
  logic [COL_W-1:0]   rcol;
  logic               rvalid;
  logic               ropaque;
  logic [COLOR_W-1:0] rcolor;
  logic [PRIO_W-1:0]  rprio;
  logic               rsemi;
  logic               robjwin;

  modport master (
    output swap, flush, we, wcol, wcolor, wprio, wsemi, wobjwin, wtransparent, re, rcol,
    input  busy, bank, rvalid, ropaque, rcolor, rprio, rsemi, robjwin
  );

  modport slave (
    input  swap, flush, we, wcol, wcolor, wprio, wsemi, wobjwin, wtransparent, re, rcol,
    output busy, bank, rvalid, ropaque, rcolor, rprio, rsemi, robjwin
  );
endinterface

// File: rtl/obj_line_pingpong_buffer_bank.sv
// One line bank: priority-arbitrated pixel write, clear-on-read port and sweep-clear port.
module obj_line_pingpong_buffer_bank #(
  parameter int COLS          = 240,
  parameter int COLOR_W       = 16,
  parameter int PRIO_W        = 2,
  parameter int CLEAR_ON_READ = 1,
  localparam int COL_W        = $clog2(COLS),
  localparam int ENTRY_W      = 3 + PRIO_W + COLOR_W
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               wr_en,
  input  logic [COL_W-1:0]   wcol,
  input  logic [COLOR_W-1:0] wcolor,
  input  logic [PRIO_W-1:0]  wprio,
  input  logic               wsemi,
  input  logic               wobjwin,
  input  logic               rd_en,
  input  logic [COL_W-1:0]   rcol,
  input  logic               sweep_en,
  input  logic [COL_W-1:0]   sweep_col,
  output logic [ENTRY_W-1:0] rdata
);
  typedef struct packed {
    logic               opaque;
    logic [PRIO_W-1:0]  prio;
    logic               semi;
    logic               objwin;
    logic [COLOR_W-1:0] color;
  } entry_t;

  localparam logic [COL_W:0] COLS_LIM = (COL_W+1)'(COLS);

  entry_t mem_q [COLS];
  entry_t mem_d [COLS];
  logic   rcol_ok;

  assign rcol_ok = ({1'b0, rcol} < COLS_LIM);
  assign rdata   = rcol_ok ? mem_q[rcol] : '0;

  always_comb begin
    mem_d = mem_q;
    if (wr_en) begin
      // OBJ-window pixels only mark the window; equal priority keeps the earlier sprite
      if (wobjwin) begin
        mem_d[wcol].objwin = 1'b1;
      end else if (!mem_q[wcol].opaque || (wprio < mem_q[wcol].prio)) begin
        mem_d[wcol].opaque = 1'b1;
        mem_d[wcol].prio   = wprio;
        mem_d[wcol].semi   = wsemi;
        mem_d[wcol].color  = wcolor;
      end
    end
    if (sweep_en) begin
      mem_d[sweep_col] = '0;
    end
    if (rd_en && rcol_ok && (CLEAR_ON_READ != 0)) begin
      mem_d[rcol] = '0;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      mem_q <= '{default: '0};
    end else begin
      mem_q <= mem_d;
    end
  end
endmodule

// File: rtl/obj_line_pingpong_buffer.sv
// Ping-pong OBJ line buffer: bank steering, flush sweep FSM with deferred swap, registered read port.
module obj_line_pingpong_buffer
  import obj_line_pingpong_buffer_pkg::*;
#(
  parameter int COLS          = OBJ_COLS,
  parameter int COLOR_W       = OBJ_COLOR_W,
  parameter int PRIO_W        = OBJ_PRIO_W,
  parameter int CLEAR_ON_READ = 1,
  localparam int COL_W        = $clog2(COLS),
  localparam int ENTRY_W      = 3 + PRIO_W + COLOR_W
) (
  input logic                        clock,
  input logic                        reset,
  obj_line_pingpong_buffer_if.slave  bus
);
  typedef struct packed {
    logic               opaque;
    logic [PRIO_W-1:0]  prio;
    logic               semi;
    logic               objwin;
    logic [COLOR_W-1:0] color;
  } entry_t;

  localparam logic [COL_W:0]   COLS_LIM = (COL_W+1)'(COLS);
  localparam logic [COL_W-1:0] LAST_COL = COL_W'(COLS - 1);

  obj_state_e       state_q, state_d;
  logic [COL_W-1:0] idx_q, idx_d;
  logic             pend_q, pend_d;
  logic             bank_q, bank_d;
  logic             rvalid_q, rvalid_d;
  entry_t           rdata_q, rdata_d;

  logic               wr_ok;
  logic               sweeping;
  entry_t             rd_entry;
  logic [ENTRY_W-1:0] bank_rdata [2];

  assign sweeping = (state_q == ST_SWEEP);
  assign wr_ok    = bus.we && !sweeping && !bus.wtransparent && ({1'b0, bus.wcol} < COLS_LIM);
  // bank_q names the render bank; the other one is on display
  assign rd_entry = bank_q ? bank_rdata[0] : bank_rdata[1];

  for (genvar g = 0; g < 2; g++) begin : g_bank
    obj_line_pingpong_buffer_bank #(
      .COLS(COLS), .COLOR_W(COLOR_W), .PRIO_W(PRIO_W), .CLEAR_ON_READ(CLEAR_ON_READ)
    ) u_bank (
      .clock     (clock),
      .reset     (reset),
      .wr_en     (wr_ok && (bank_q == 1'(g))),
      .wcol      (bus.wcol),
      .wcolor    (bus.wcolor),
      .wprio     (bus.wprio),
      .wsemi     (bus.wsemi),
      .wobjwin   (bus.wobjwin),
      .rd_en     (bus.re && (bank_q != 1'(g))),
      .rcol      (bus.rcol),
      .sweep_en  (sweeping && (bank_q == 1'(g))),
      .sweep_col (idx_q),
      .rdata     (bank_rdata[g])
    );
  end

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    pend_d   = pend_q;
    bank_d   = bank_q;
    rvalid_d = bus.re;
    rdata_d  = bus.re ? rd_entry : rdata_q;
    case (state_q)
      ST_IDLE: begin
        if (bus.swap) bank_d = ~bank_q;
        if (bus.flush) begin
          state_d = ST_SWEEP;
          idx_d   = '0;
        end
      end
      ST_SWEEP: begin
        idx_d = idx_q + 1'b1;
        if (bus.swap) pend_d = 1'b1;
        // a swap requested during the sweep lands on the edge that ends it
        if (idx_q == LAST_COL) begin
          state_d = ST_IDLE;
          idx_d   = '0;
          pend_d  = 1'b0;
          if (pend_q || bus.swap) bank_d = ~bank_q;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      idx_q    <= '0;
      pend_q   <= 1'b0;
      bank_q   <= 1'b0;
      rvalid_q <= 1'b0;
      rdata_q  <= '0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      pend_q   <= pend_d;
      bank_q   <= bank_d;
      rvalid_q <= rvalid_d;
      rdata_q  <= rdata_d;
    end
  end

  assign bus.busy    = sweeping;
  assign bus.bank    = bank_q;
  assign bus.rvalid  = rvalid_q;
  assign bus.ropaque = rdata_q.opaque;
  assign bus.rcolor  = rdata_q.color;
  assign bus.rprio   = rdata_q.prio;
  assign bus.rsemi   = rdata_q.semi;
  assign bus.robjwin = rdata_q.objwin;
endmodule

// File: tb/tb_obj_line_pingpong_buffer.sv
// Randomised and directed bench for the OBJ ping-pong line buffer against a line-level reference model.
module tb_obj_line_pingpong_buffer;
  localparam int COLS    = 240;
  localparam int COL_W   = 8;
  localparam int COLOR_W = 16;
  localparam int PRIO_W  = 2;

  typedef struct packed {
    logic               opaque;
    logic [PRIO_W-1:0]  prio;
    logic               semi;
    logic               objwin;
    logic [COLOR_W-1:0] color;
  } ent_t;

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  obj_line_pingpong_buffer_if #(.COL_W(COL_W), .COLOR_W(COLOR_W), .PRIO_W(PRIO_W)) bus ();

  obj_line_pingpong_buffer #(.COLS(COLS), .COLOR_W(COLOR_W), .PRIO_W(PRIO_W), .CLEAR_ON_READ(1)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  int n_cmp = 0;
  int n_err = 0;

  // reference model: two lines of entries, render-bank index, remaining sweep cycles
  ent_t mdl [2][COLS];
  int   m_bank;
  int   sweep_left;
  bit   pend;
  bit   e_rvalid;
  ent_t e_r;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic model_update();
    ent_t e;
    int   r;
    if (reset) begin
      for (int b = 0; b < 2; b++) for (int c = 0; c < COLS; c++) mdl[b][c] = '0;
      m_bank = 0; sweep_left = 0; pend = 0; e_rvalid = 0; e_r = '0;
      return;
    end
    r = m_bank;
    e_rvalid = bus.re;
    if (bus.re) begin
      if (int'(bus.rcol) < COLS) begin
        e_r = mdl[1-r][bus.rcol];
        mdl[1-r][bus.rcol] = '0;
      end else begin
        e_r = '0;
      end
    end
    if (bus.we && sweep_left == 0 && int'(bus.wcol) < COLS && !bus.wtransparent) begin
      e = mdl[r][bus.wcol];
      if (bus.wobjwin) e.objwin = 1'b1;
      else if (!e.opaque || bus.wprio < e.prio) begin
        e.opaque = 1'b1; e.prio = bus.wprio; e.semi = bus.wsemi; e.color = bus.wcolor;
      end
      mdl[r][bus.wcol] = e;
    end
    if (sweep_left > 0) begin
      mdl[r][COLS - sweep_left] = '0;
      if (bus.swap) pend = 1;
      sweep_left--;
      if (sweep_left == 0) begin
        if (pend) m_bank = 1 - m_bank;
        pend = 0;
      end
    end else begin
      if (bus.swap) m_bank = 1 - m_bank;
      if (bus.flush) sweep_left = COLS;
    end
  endtask

  task automatic idle_inputs();
    bus.swap = 0; bus.flush = 0; bus.we = 0; bus.wcol = '0; bus.wcolor = '0; bus.wprio = '0;
    bus.wsemi = 0; bus.wobjwin = 0; bus.wtransparent = 0; bus.re = 0; bus.rcol = '0;
  endtask

  task automatic step();
    model_update();
    @(posedge clock);
    #1;
    chk("busy",    32'(bus.busy),    32'(sweep_left > 0));
    chk("bank",    32'(bus.bank),    32'(m_bank));
    chk("rvalid",  32'(bus.rvalid),  32'(e_rvalid));
    chk("ropaque", 32'(bus.ropaque), 32'(e_r.opaque));
    chk("rcolor",  32'(bus.rcolor),  32'(e_r.color));
    chk("rprio",   32'(bus.rprio),   32'(e_r.prio));
    chk("rsemi",   32'(bus.rsemi),   32'(e_r.semi));
    chk("robjwin", 32'(bus.robjwin), 32'(e_r.objwin));
    idle_inputs();
  endtask

  task automatic wr(input int col, input int color, input int prio, input bit semi, input bit objwin, input bit transp);
    bus.we = 1; bus.wcol = COL_W'(col); bus.wcolor = COLOR_W'(color); bus.wprio = PRIO_W'(prio);
    bus.wsemi = semi; bus.wobjwin = objwin; bus.wtransparent = transp;
    step();
  endtask

  task automatic rd(input int col);
    bus.re = 1; bus.rcol = COL_W'(col);
    step();
  endtask

  task automatic do_swap();
    bus.swap = 1;
    step();
  endtask

  int  busy_cycles;
  bit  bank_before;
  bit  prev_busy;

  initial begin
    idle_inputs();
    reset = 1;
    step();
    chk("reset_busy", 32'(bus.busy), 32'h0);
    chk("reset_bank", 32'(bus.bank), 32'h0);
    chk("reset_rvalid", 32'(bus.rvalid), 32'h0);
    reset = 0;
    step();

    // priority: lower value replaces
    wr(5, 16'h1234, 2, 0, 0, 0);
    wr(5, 16'h0F0F, 1, 1, 0, 0);
    do_swap();
    rd(5);
    chk("t1_opaque", 32'(bus.ropaque), 32'h1);
    chk("t1_color",  32'(bus.rcolor),  32'h0F0F);
    chk("t1_prio",   32'(bus.rprio),   32'h1);

    // equal priority keeps first; transparent ignored
    wr(7, 16'hAAAA, 1, 0, 0, 0);
    wr(7, 16'h5555, 1, 0, 0, 0);
    wr(7, 16'h1111, 0, 0, 0, 1);
    do_swap();
    rd(7);
    chk("t2_color", 32'(bus.rcolor), 32'hAAAA);

    // objwin only, then clear-on-read
    wr(9, 16'h7777, 0, 0, 1, 0);
    do_swap();
    rd(9);
    chk("t3_objwin", 32'(bus.robjwin), 32'h1);
    chk("t3_opaque", 32'(bus.ropaque), 32'h0);
    chk("t3_color",  32'(bus.rcolor),  32'h0);
    rd(9);
    chk("t3_reread", {bus.ropaque, bus.robjwin, bus.rsemi, 13'h0, bus.rcolor}, 32'h0);

    // fill the render bank, flush, swap mid-sweep
    for (int c = 0; c < COLS; c++) wr(c, int'($urandom_range(1, 16'hFFFF)), int'($urandom_range(0, 3)), 1'($urandom), 0, 0);
    bus.flush = 1;
    step();
    busy_cycles = 0;
    bank_before = bus.bank;
    prev_busy = bus.busy;
    for (int i = 0; i < 300 && bus.busy; i++) begin
      busy_cycles++;
      if (i == 9) bus.swap = 1;
      else if (i == 20) bus.flush = 1;
      prev_busy = bus.busy;
      step();
      if (prev_busy && !bus.busy) chk("t4_bank_on_fall", 32'(bus.bank), 32'(!bank_before));
    end
    chk("t4_busy_cycles", 32'(busy_cycles), 32'd240);
    chk("t4_busy_fell", 32'(bus.busy), 32'h0);
    rd(0);
    chk("t4_read0", 32'(bus.ropaque), 32'h0);
    rd(239);
    chk("t4_read239", 32'(bus.rcolor), 32'h0);

    // out-of-range read and write
    rd(245);
    chk("t5_rvalid", 32'(bus.rvalid), 32'h1);
    chk("t5_fields", {bus.ropaque, bus.robjwin, bus.rsemi, bus.rprio, 11'h0, bus.rcolor}, 32'h0);
    wr(240, 16'hBEEF, 0, 0, 0, 0);
    wr(255, 16'hBEEF, 0, 0, 0, 0);

    // reset mid-sweep after writes
    for (int c = 0; c < COLS; c += 40) wr(c, 16'h4321, 0, 0, 0, 0);
    do_swap();
    for (int c = 0; c < COLS; c += 40) wr(c, 16'h8765, 0, 0, 0, 0);
    bus.flush = 1;
    step();
    for (int i = 0; i < 5; i++) step();
    reset = 1;
    step();
    reset = 0;
    chk("t6_busy", 32'(bus.busy), 32'h0);
    chk("t6_bank", 32'(bus.bank), 32'h0);
    for (int pass = 0; pass < 2; pass++) begin
      rd(0);   chk("t6_col0",   32'(bus.rcolor), 32'h0);
      rd(120); chk("t6_col120", 32'(bus.rcolor), 32'h0);
      rd(239); chk("t6_col239", 32'(bus.rcolor), 32'h0);
      do_swap();
    end

    // random traffic
    for (int i = 0; i < 2500; i++) begin
      bus.we           = ($urandom_range(0, 99) < 55);
      bus.wcol         = COL_W'($urandom_range(0, 24) == 0 ? $urandom_range(240, 255) : $urandom_range(0, 15));
      bus.wcolor       = COLOR_W'($urandom);
      bus.wprio        = PRIO_W'($urandom);
      bus.wsemi        = 1'($urandom);
      bus.wobjwin      = ($urandom_range(0, 99) < 15);
      bus.wtransparent = ($urandom_range(0, 99) < 15);
      bus.re           = ($urandom_range(0, 99) < 40);
      bus.rcol         = COL_W'($urandom_range(0, 24) == 0 ? $urandom_range(240, 255) : $urandom_range(0, 15));
      bus.swap         = ($urandom_range(0, 99) < 6);
      bus.flush        = ($urandom_range(0, 999) < 4);
      reset            = ($urandom_range(0, 999) < 2);
      step();
      reset = 0;
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
